// File: rtl/data_sram_like_bridge.sv
// data_sram_like_bridge: CPU data SRAM port to sram-like req/addr_ok/data_ok bridge.
// Optional kseg0/kseg1 address translation under BRIDGE_KSEG_TRANSLATE_EN.
module data_sram_like_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [31:0]       rdata
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t            state_q, state_d;
  logic              wr_q, wr_d, discard_q, discard_d, kill;
  logic [1:0]        size_q, size_d, enc_size, enc_lo;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_x;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
`ifdef BRIDGE_KSEG_TRANSLATE_EN
  assign addr_x = (cpu_addr[ADDR_W-1 -: 2] == 2'b10) ? {3'b000, cpu_addr[ADDR_W-4:0]} : cpu_addr;
`else
  assign addr_x = cpu_addr;
`endif
  always_comb begin
    enc_size = 2'd2;
    enc_lo   = 2'd0;
    case (cpu_wen)
      4'b0001: begin enc_size = 2'd0; enc_lo = 2'd0; end
      4'b0010: begin enc_size = 2'd0; enc_lo = 2'd1; end
      4'b0100: begin enc_size = 2'd0; enc_lo = 2'd2; end
      4'b1000: begin enc_size = 2'd0; enc_lo = 2'd3; end
      4'b0011: begin enc_size = 2'd1; enc_lo = 2'd0; end
      4'b1100: begin enc_size = 2'd1; enc_lo = 2'd2; end
      default: begin enc_size = 2'd2; enc_lo = 2'd0; end
    endcase
  end
  // a flush arriving with data_ok in the same cycle discards that response too
  assign kill = discard_q | flush;
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    discard_d = discard_q;
    case (state_q)
      IDLE: if (cpu_en && !flush) begin
        state_d = ADDR;
        wr_d    = |cpu_wen;
        size_d  = enc_size;
        addr_d  = {addr_x[ADDR_W-1:2], enc_lo};
        wdata_d = cpu_wdata;
      end
      ADDR: if (addr_ok && data_ok) begin
        state_d = flush ? IDLE : DONE;
        rdata_d = (!flush && !wr_q) ? rdata : rdata_q;
      end else if (addr_ok) begin
        state_d   = DATA;
        discard_d = flush;
      end else if (flush) state_d = IDLE;
      DATA: if (data_ok) begin
        state_d   = kill ? IDLE : DONE;
        rdata_d   = (!kill && !wr_q) ? rdata : rdata_q;
        discard_d = 1'b0;
      end else discard_d = kill;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      discard_q <= discard_d;
    end
  end
  assign req       = state_q == ADDR;
  assign wr        = wr_q;
  assign size      = size_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign cpu_rdata = rdata_q;
  assign cpu_stall = (state_q == ADDR) || (state_q == DATA) || (state_q == IDLE && cpu_en && !flush);
endmodule

// File: tb/tb_data_sram_like_bridge.sv
// tb_data_sram_like_bridge: table-driven vectors plus hand-written multi-cycle sequences.
module tb_data_sram_like_bridge;
  logic        clk = 1'b0, resetn = 1'b0, cpu_en = 1'b0, flush = 1'b0;
  logic        addr_ok = 1'b0, data_ok = 1'b0;
  logic [3:0]  cpu_wen = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, rdata = '0;
  logic [31:0] cpu_rdata, addr, wdata;
  logic        cpu_stall, req, wr;
  logic [1:0]  size;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic [3:0]  wen;
    logic [31:0] a, wd, rd, ea, er;
    logic        ew;
    logic [1:0]  es;
  } vec_t;
  vec_t vecs[13];
  data_sram_like_bridge #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .flush(flush),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic start(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd);
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = a; cpu_wdata = wd;
    addr_ok = 1'b0; data_ok = 1'b0; flush = 1'b0;
    #1;
    chk("idle_stall", cpu_stall, 1);
    chk("idle_req", req, 0);
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{4'b0000, 32'h1000_0007, 32'h0,        32'h1122_3344, 32'h1000_0004, 32'h1122_3344, 1'b0, 2'd2};
    vecs[1]  = '{4'b0001, 32'h2000_0002, 32'h0000_00AA, 32'hFFFF_FFFF, 32'h2000_0000, 32'h1122_3344, 1'b1, 2'd0};
    vecs[2]  = '{4'b0010, 32'h0000_0100, 32'h0000_BB00, 32'h0,         32'h0000_0101, 32'h1122_3344, 1'b1, 2'd0};
    vecs[3]  = '{4'b1000, 32'h0000_0200, 32'hCC00_0000, 32'h0,         32'h0000_0203, 32'h1122_3344, 1'b1, 2'd0};
    vecs[4]  = '{4'b0011, 32'h0000_0303, 32'h0000_1234, 32'h0,         32'h0000_0300, 32'h1122_3344, 1'b1, 2'd1};
    vecs[5]  = '{4'b1100, 32'h0000_0400, 32'h5678_0000, 32'h0,         32'h0000_0402, 32'h1122_3344, 1'b1, 2'd1};
    vecs[6]  = '{4'b1111, 32'h0000_0503, 32'hA5A5_A5A5, 32'h0,         32'h0000_0500, 32'h1122_3344, 1'b1, 2'd2};
    vecs[7]  = '{4'b0101, 32'h0000_0601, 32'h0011_0022, 32'h0,         32'h0000_0600, 32'h1122_3344, 1'b1, 2'd2};
    vecs[8]  = '{4'b0000, 32'h0000_0800, 32'h0,        32'hCAFE_F00D, 32'h0000_0800, 32'hCAFE_F00D, 1'b0, 2'd2};
    vecs[9]  = '{4'b0100, 32'h0000_1003, 32'h00AB_0000, 32'h0,         32'h0000_1002, 32'hCAFE_F00D, 1'b1, 2'd0};
`ifdef BRIDGE_KSEG_TRANSLATE_EN
    vecs[10] = '{4'b0000, 32'hBFC0_0000, 32'h0,        32'h0BAD_F00D, 32'h1FC0_0000, 32'h0BAD_F00D, 1'b0, 2'd2};
`else
    vecs[10] = '{4'b0000, 32'hBFC0_0000, 32'h0,        32'h0BAD_F00D, 32'hBFC0_0000, 32'h0BAD_F00D, 1'b0, 2'd2};
`endif
    vecs[11] = '{4'b0000, 32'h0040_0000, 32'h0,        32'h7654_3210, 32'h0040_0000, 32'h7654_3210, 1'b0, 2'd2};
    vecs[12] = '{4'b0000, 32'hC000_0000, 32'h0,        32'h0101_0101, 32'hC000_0000, 32'h0101_0101, 1'b0, 2'd2};
    tick; tick;
    chk("rst_req", req, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rdata", cpu_rdata, 0);
    resetn = 1'b1;
    tick;
    for (int i = 0; i < 13; i++) begin
      start(vecs[i].wen, vecs[i].a, vecs[i].wd);
      addr_ok = 1'b1; data_ok = 1'b1; rdata = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_req", i), req, 1);
      chk($sformatf("v%0d_wr", i), wr, vecs[i].ew);
      chk($sformatf("v%0d_size", i), size, vecs[i].es);
      chk($sformatf("v%0d_addr", i), addr, vecs[i].ea);
      if (vecs[i].ew) chk($sformatf("v%0d_wdata", i), wdata, vecs[i].wd);
      chk($sformatf("v%0d_stall", i), cpu_stall, 1);
      tick;
      addr_ok = 1'b0; data_ok = 1'b0; cpu_en = 1'b0;
      #1;
      chk($sformatf("v%0d_done_stall", i), cpu_stall, 0);
      chk($sformatf("v%0d_done_req", i), req, 0);
      chk($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].er);
      tick;
      chk($sformatf("v%0d_hold", i), cpu_rdata, vecs[i].er);
    end
    // read word with data_ok two cycles after addr_ok
    start(4'b0000, 32'h1FC0_0010, 32'h0);
    addr_ok = 1'b1; #1;
    chk("rd_req", req, 1); chk("rd_size", size, 2); chk("rd_addr", addr, 32'h1FC0_0010); chk("rd_stall1", cpu_stall, 1);
    tick; addr_ok = 1'b0; #1;
    chk("rd_req_drop", req, 0); chk("rd_stall2", cpu_stall, 1);
    tick; data_ok = 1'b1; rdata = 32'hDEAD_BEEF; #1;
    chk("rd_req_low", req, 0); chk("rd_stall3", cpu_stall, 1);
    tick; data_ok = 1'b0; cpu_en = 1'b0; #1;
    chk("rd_done_stall", cpu_stall, 0); chk("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
    tick;
    // backpressure: addr_ok withheld for five cycles
    start(4'b1111, 32'h0000_2000, 32'h1234_5678);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_req", req, 1); chk("bp_addr", addr, 32'h0000_2000); chk("bp_size", size, 2);
      chk("bp_wdata", wdata, 32'h1234_5678); chk("bp_stall", cpu_stall, 1);
      tick;
    end
    addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h9999_9999;
    tick; addr_ok = 1'b0; data_ok = 1'b0; cpu_en = 1'b0; #1;
    chk("bp_done_stall", cpu_stall, 0); chk("bp_rdata", cpu_rdata, 32'hDEAD_BEEF);
    tick;
    // flush in ADDR before addr_ok
    start(4'b0000, 32'h0000_3000, 32'h0);
    flush = 1'b1; #1;
    chk("fa_req", req, 1);
    tick; flush = 1'b0; cpu_en = 1'b0; #1;
    chk("fa_req_drop", req, 0); chk("fa_stall", cpu_stall, 0);
    tick;
    chk("fa_idle_req", req, 0); chk("fa_idle_stall", cpu_stall, 0);
    // flush in DATA: response consumed, rdata untouched
    start(4'b0000, 32'h0000_4000, 32'h0);
    addr_ok = 1'b1;
    tick; addr_ok = 1'b0; cpu_en = 1'b0; flush = 1'b1; #1;
    chk("fd_stall1", cpu_stall, 1);
    tick; flush = 1'b0; #1;
    chk("fd_stall2", cpu_stall, 1);
    tick; data_ok = 1'b1; rdata = 32'h5555_5555; #1;
    chk("fd_stall3", cpu_stall, 1);
    tick; data_ok = 1'b0; #1;
    chk("fd_rdata", cpu_rdata, 32'hDEAD_BEEF); chk("fd_stall4", cpu_stall, 0); chk("fd_req", req, 0);
    tick;
    chk("fd_idle_rdata", cpu_rdata, 32'hDEAD_BEEF);
    // reset while waiting in DATA
    start(4'b0000, 32'h0000_5000, 32'h0);
    addr_ok = 1'b1;
    tick; addr_ok = 1'b0; #1;
    chk("rm_stall_pre", cpu_stall, 1);
    resetn = 1'b0; cpu_en = 1'b0;
    tick;
    chk("rm_req", req, 0); chk("rm_stall", cpu_stall, 0); chk("rm_rdata", cpu_rdata, 0);
    resetn = 1'b1;
    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_sram_like_bridge.md
Name: data_sram_like_bridge

Overview:
- Sits directly downstream of the CPU core's data SRAM port (en/wen/addr/wdata/rdata).
- Converts single-cycle SRAM accesses into the handshake-based sram-like protocol (req/addr_ok/data_ok) used by the cache/AXI layer.
- Returns a stall to the pipeline until each access completes.
- Handles exception flush and optional kseg address translation.

Parameters:
- ADDR_W, 32, address width of CPU and memory sides.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous reset, active low.
- cpu_en  in  1  CPU data access enable.
- cpu_wen  in  4  byte write enables; 0 means read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  write data, already byte-lane aligned.
- cpu_rdata  out  32  read data, valid in the DONE cycle.
- cpu_stall  out  1  pipeline stall request.
- flush  in  1  exception/redirect; cancels the current access.
- req  out  1  sram-like request.
- wr  out  1  1 = write.
- size  out  2  0 = byte, 1 = half, 2 = word.
- addr  out  ADDR_W  request address.
- wdata  out  32  write data.
- addr_ok  in  1  request accepted.
- data_ok  in  1  read data returned / write completed.
- rdata  in  32  read data.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE, command and rdata registers cleared, discard=0.
  - Outputs req=0, cpu_stall=0, cpu_rdata=0.
  - Reset mid-transaction abandons it at once; downstream shares resetn.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - cpu_en=1 and flush=0: latch wr=|cpu_wen, size, addr, wdata; go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - req=1; wr/size/addr/wdata driven from the latched registers and held stable.
  - addr_ok=1 and data_ok=1: go to DONE.
  - addr_ok=1 only: go to DATA.
  - flush=1 and addr_ok=0: req withdrawn, go to IDLE.
  - flush=1 and addr_ok=1: set discard, go to DATA.
- DATA:
  - req=0; wait for data_ok.
  - flush in this state sets discard.
  - data_ok=1 and discard=0: latch rdata (reads only), go to DONE.
  - data_ok=1 and discard=1: go to IDLE, clear discard.
- DONE:
  - cpu_stall=0, so the CPU advances on this edge.
  - cpu_rdata=latched value; go to IDLE.
- cpu_stall:
  - 1 when state=ADDR or DATA, or when state=IDLE and cpu_en=1 and flush=0.
  - 0 otherwise.
- cpu_rdata:
  - Holds its last latched value outside DONE.
  - Writes do not change it.
- Size/address encoding from cpu_wen:
  - 0001/0010/0100/1000: size 0, addr[1:0] = lane 0/1/2/3.
  - 0011: size 1, addr[1:0]=0.
  - 1100: size 1, addr[1:0]=2.
  - 1111 or read (0000): size 2, addr[1:0]=0.
  - Any other pattern: size 2, addr[1:0]=0.
- Minimum access latency:
  - Entry cycle in IDLE, ADDR, DONE = 3 cycles when addr_ok and data_ok arrive together in the first ADDR cycle.
  - Back-to-back accesses: the next access starts in the IDLE cycle right after DONE.
- No outstanding-request pipelining: at most one transaction is in flight.

Optional Feature:
- Macro: BRIDGE_KSEG_TRANSLATE_EN.
- Defined:
  - Latched addr passes through fixed MIPS translation.
  - 0x8000_0000–0xBFFF_FFFF (kseg0/kseg1): upper 3 bits cleared.
  - All other addresses pass unchanged.
- Not defined: addr = cpu_addr unmodified.

Test Plan:
- Read word:
  - Stimulus: cpu_en=1, wen=0, addr=0x1FC0_0010; addr_ok on first ADDR cycle, data_ok 2 cycles later with rdata=0xDEADBEEF.
  - Required: req=1 for exactly 1 cycle, size=2; cpu_stall high 4 cycles then low in DONE; cpu_rdata=0xDEADBEEF.
- Byte write:
  - Stimulus: wen=0100, addr=0x0000_1003, wdata=0x00AB0000.
  - Required: wr=1, size=0, addr=0x0000_1002, wdata=0x00AB0000; cpu_rdata unchanged after completion.
- Backpressure:
  - Stimulus: addr_ok held 0 for 5 cycles.
  - Required: req, addr, size, wdata stable throughout; cpu_stall=1 throughout.
- Flush:
  - Flush in ADDR before addr_ok: req drops next cycle; state returns to IDLE; no DONE.
  - Flush in DATA: data_ok consumed; cpu_rdata not updated; cpu_stall=1 until data_ok.
- Reset mid-transaction:
  - Stimulus: resetn=0 in DATA state.
  - Required: next cycle req=0, cpu_stall=0, cpu_rdata=0.
- Translation with BRIDGE_KSEG_TRANSLATE_EN:
  - cpu_addr=0xBFC0_0000 → addr=0x1FC0_0000.
  - cpu_addr=0x0040_0000 → addr=0x0040_0000.
  - Without the macro, addr=0xBFC0_0000.
